regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: register and port data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5: address width; register count DEPTH = 2**ADDR_W.
REQ-003 SHALL provide parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL provide parameter NWR, default 2: number of write ports, 1..4.
REQ-005 SHALL provide parameter ZERO_R0, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-006 SHALL provide parameter DBG_IDX, default 3: index of the register exposed on dbg_val.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 stall  input  1  holds all read-data outputs when high.
REQ-010 raddr  input  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 rdata  output  NRD*DATA_W  registered read data, port i at bits [i*DATA_W +: DATA_W].
REQ-012 wen  input  NWR  write enables, one bit per port.
REQ-013 waddr  input  NWR*ADDR_W  write addresses, packed as raddr.
REQ-014 wdata  input  NWR*DATA_W  write data, packed as rdata.
REQ-015 dbg_val  output  DATA_W  combinational current contents of register DBG_IDX.
REQ-016 wr_conflict  output  1  registered flag: a write-address collision was resolved in the previous cycle.

Function
REQ-017 Writes SHALL commit on the rising edge of clk and be visible in storage one cycle later; write latency 1.
REQ-018 When two or more enabled write ports target the same address, the lowest-numbered port SHALL win; higher ports to that address are dropped; ports to distinct addresses all commit.
REQ-019 wr_conflict SHALL be 1 for exactly the cycle after any edge at which a collision per REQ-018 occurred, else 0; stall does not affect it.
REQ-020 Each read port SHALL register its result at the rising edge when stall=0; read latency 1; when stall=1, rdata SHALL hold its previous value while writes still commit.
REQ-021 With ZERO_R0=1, reading address 0 SHALL return 0, writes to address 0 SHALL be discarded, and a write to address 0 SHALL NOT count as a collision.
REQ-022 With ZERO_R0=0, register 0 SHALL behave as any other register.
REQ-023 A read and a write to the same address at the same edge SHALL follow REQ-033 or REQ-034.
REQ-024 dbg_val SHALL reflect the storage of DBG_IDX combinationally, with no bypass; with ZERO_R0=1 and DBG_IDX=0 it SHALL be 0.
REQ-025 Out-of-range parameters (NRD or NWR outside 1..4, DBG_IDX >= DEPTH) SHALL cause an elaboration-time error.

Reset
REQ-026 rst_n low SHALL asynchronously clear every register to 0, every rdata lane to 0, and wr_conflict to 0.
REQ-027 Writes and reads presented while rst_n is low SHALL be ignored; the first write commits at the first rising edge with rst_n high.
REQ-028 Reset asserted mid-stall SHALL clear rdata immediately; after release the block SHALL follow stall normally.

Configuration
REQ-029 Macro REGFILE_MP_BYPASS_EN SHALL select the same-edge read/write behaviour.
REQ-030 With the macro defined, a read port sampling an address written at the same edge SHALL capture the winning write data (write-first).
REQ-031 With the macro undefined, that read port SHALL capture the pre-write storage value (read-first).
REQ-032 Bypass SHALL respect REQ-018 priority and REQ-021 zero-register rules.
REQ-033 Defined: rdata = winning wdata for the matching address.
REQ-034 Undefined: rdata = old storage; the new value is visible on the next read.

Verification
REQ-035 Reset: rst_n=0 with random writes -> all rdata=0, dbg_val=0, wr_conflict=0; after release, reading r5 -> 0.
REQ-036 Collision: wen=2'b11, waddr both 7, wdata0=0xAAAA0000, wdata1=0x5555FFFF -> r7=0xAAAA0000 next cycle; wr_conflict=1 for one cycle.
REQ-037 Bypass: write r4=0x12345678 while reading r4 -> rdata=0x12345678 if REGFILE_MP_BYPASS_EN is defined, else the old value 0, then 0x12345678 on the next read.
REQ-038 Stall: rdata=0x11 on r9; assert stall, write r9=0x22 -> rdata stays 0x11; release stall -> rdata=0x22.
REQ-039 Zero register: write r0=0xFFFFFFFF together with port1 writing r0 -> r0 reads 0 and wr_conflict=0; ZERO_R0=0 build -> r0 reads 0xFFFFFFFF.
REQ-040 Debug and parameters: NRD=4, NWR=1, DATA_W=16, write r3=0xBEEF -> dbg_val=0xBEEF in the same cycle as the commit edge, and all four ports return 0xBEEF.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports, NWR prioritised write ports.
// Define REGFILE_MP_BYPASS_EN for write-first same-edge reads; read-first otherwise.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1,
    parameter int DBG_IDX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]     dbg_val,
    output logic                  wr_conflict
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam bit                HAS_ZERO = (ZERO_R0 != 0);
    localparam logic [ADDR_W-1:0] DBG_A    = ADDR_W'(DBG_IDX);

    generate
        if (NRD < 1 || NRD > 4) begin : g_bad_nrd
            $error("regfile_mp: NRD must be in 1..4");
        end
        if (NWR < 1 || NWR > 4) begin : g_bad_nwr
            $error("regfile_mp: NWR must be in 1..4");
        end
        if (DBG_IDX < 0 || DBG_IDX >= DEPTH) begin : g_bad_dbg
            $error("regfile_mp: DBG_IDX must address an existing register");
        end
    endgenerate

    logic [ADDR_W-1:0] wa [NWR];
    logic [DATA_W-1:0] wd [NWR];
    logic [ADDR_W-1:0] ra [NRD];

    genvar g;
    generate
        for (g = 0; g < NWR; g++) begin : g_wunpack
            assign wa[g] = waddr[g*ADDR_W +: ADDR_W];
            assign wd[g] = wdata[g*DATA_W +: DATA_W];
        end
        for (g = 0; g < NRD; g++) begin : g_runpack
            assign ra[g] = raddr[g*ADDR_W +: ADDR_W];
        end
    endgenerate

    // A write to the hard-wired zero register is not a real write, so it can neither win nor collide.
    logic [NWR-1:0] wvalid;
    always_comb begin
        wvalid = '0;
        for (int j = 0; j < NWR; j++) begin
            wvalid[j] = wen[j] && !(HAS_ZERO && (wa[j] == '0));
        end
    end

    logic [NWR-1:0] wwin;
    logic           conflict_d;
    always_comb begin
        wwin       = '0;
        conflict_d = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            wwin[j] = wvalid[j];
            for (int k = 0; k < j; k++) begin
                if (wvalid[k] && (wa[k] == wa[j])) begin
                    wwin[j] = 1'b0;
                end
            end
            if (wvalid[j] && !wwin[j]) begin
                conflict_d = 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Winners always target distinct addresses, so the loop order is irrelevant.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NWR; j++) begin
            if (wwin[j]) begin
                mem_d[wa[j]] = wd[j];
            end
        end
    end

    logic [DATA_W-1:0] rd_val [NRD];
    logic [DATA_W-1:0] rd_d   [NRD];
    logic [DATA_W-1:0] rd_q   [NRD];

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_val[i] = mem_q[ra[i]];
            if (HAS_ZERO && (ra[i] == '0)) begin
                rd_val[i] = '0;
            end
`ifdef REGFILE_MP_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wwin[j] && (wa[j] == ra[i])) begin
                    rd_val[i] = wd[j];
                end
            end
`endif
            rd_d[i] = stall ? rd_q[i] : rd_val[i];
        end
    end

    logic conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
            for (int i = 0; i < NRD; i++) begin
                rd_q[i] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_q       <= rd_d;
            conflict_q <= conflict_d;
        end
    end

    generate
        for (g = 0; g < NRD; g++) begin : g_rpack
            assign rdata[g*DATA_W +: DATA_W] = rd_q[g];
        end
    endgenerate

    assign dbg_val     = (HAS_ZERO && (DBG_IDX == 0)) ? '0 : mem_q[DBG_A];
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default 2R/2W instance and a 4R/1W 16-bit instance without a zero register.
module tb_regfile_mp;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [31:0] dbg_val;
    logic        wr_conflict;

    logic [19:0] b_raddr;
    logic [63:0] b_rdata;
    logic [0:0]  b_wen;
    logic [4:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [15:0] b_dbg;
    logic        b_conf;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .raddr(raddr), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .dbg_val(dbg_val), .wr_conflict(wr_conflict)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(5), .NRD(4), .NWR(1), .ZERO_R0(0), .DBG_IDX(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .raddr(b_raddr), .rdata(b_rdata),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
        .dbg_val(b_dbg), .wr_conflict(b_conf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset held with writes and reads presented on both instances
        rst_n   = 1'b0;
        stall   = 1'b0;
        wen     = 2'b11;
        waddr   = {5'd3, 5'd3};
        wdata   = {32'hCAFE0002, 32'hCAFE0001};
        raddr   = {5'd3, 5'd5};
        b_wen   = 1'b1;
        b_waddr = 5'd3;
        b_wdata = 16'h1234;
        b_raddr = {4{5'd3}};
        tick();
        tick();
        check("rst_rdata0", rdata[31:0], 32'h0);
        check("rst_rdata1", rdata[63:32], 32'h0);
        check("rst_dbg", dbg_val, 32'h0);
        check("rst_conflict", wr_conflict, 1'b0);
        check("rst_b_dbg", b_dbg, 16'h0);

        rst_n = 1'b1;
        wen   = 2'b00;
        b_wen = 1'b0;
        raddr = {5'd0, 5'd5};
        tick();
        check("r5_after_rst", rdata[31:0], 32'h0);
        check("dbg_after_rst", dbg_val, 32'h0);

        // Collision on r7: port 0 wins
        wen   = 2'b11;
        waddr = {5'd7, 5'd7};
        wdata = {32'h5555FFFF, 32'hAAAA0000};
        raddr = {5'd0, 5'd7};
        tick();
        check("coll_flag", wr_conflict, 1'b1);
        check("coll_sameedge", rdata[31:0], BYP ? 32'hAAAA0000 : 32'h0);
        wen = 2'b00;
        tick();
        check("coll_flag_clear", wr_conflict, 1'b0);
        check("coll_r7", rdata[31:0], 32'hAAAA0000);

        // Distinct addresses both commit
        wen   = 2'b11;
        waddr = {5'd11, 5'd10};
        wdata = {32'h00001111, 32'h00001010};
        tick();
        check("distinct_noflag", wr_conflict, 1'b0);
        wen   = 2'b00;
        raddr = {5'd11, 5'd10};
        tick();
        check("distinct_r10", rdata[31:0], 32'h00001010);
        check("distinct_r11", rdata[63:32], 32'h00001111);

        // Disabled port 0 does not block port 1 or collide
        wen   = 2'b10;
        waddr = {5'd12, 5'd12};
        wdata = {32'h0000C0C0, 32'h0000DEAD};
        raddr = {5'd0, 5'd12};
        tick();
        check("gated_noflag", wr_conflict, 1'b0);
        wen = 2'b00;
        tick();
        check("gated_r12", rdata[31:0], 32'h0000C0C0);

        // Same-edge read/write of r4
        wen   = 2'b01;
        waddr = {5'd0, 5'd4};
        wdata = {32'h0, 32'h12345678};
        raddr = {5'd0, 5'd4};
        tick();
        check("byp_r4_edge", rdata[31:0], BYP ? 32'h12345678 : 32'h0);
        wen = 2'b00;
        tick();
        check("byp_r4_next", rdata[31:0], 32'h12345678);

        // Same-edge read under collision follows the winner
        wen   = 2'b11;
        waddr = {5'd13, 5'd13};
        wdata = {32'h00000031, 32'h00000013};
        raddr = {5'd13, 5'd0};
        tick();
        check("byp_prio_edge", rdata[63:32], BYP ? 32'h00000013 : 32'h0);
        check("byp_prio_flag", wr_conflict, 1'b1);
        wen = 2'b00;
        tick();
        check("byp_prio_next", rdata[63:32], 32'h00000013);

        // Debug tap shows r3 right after the commit edge
        check("dbg_pre", dbg_val, 32'h0);
        wen   = 2'b10;
        waddr = {5'd3, 5'd0};
        wdata = {32'hBEEF0003, 32'h0};
        tick();
        check("dbg_commit", dbg_val, 32'hBEEF0003);
        wen = 2'b00;

        // Stall holds read data while writes and the conflict flag proceed
        wen   = 2'b01;
        waddr = {5'd0, 5'd9};
        wdata = {32'h0, 32'h00000011};
        raddr = {5'd0, 5'd9};
        tick();
        wen = 2'b00;
        tick();
        check("stall_pre", rdata[31:0], 32'h00000011);
        stall = 1'b1;
        wen   = 2'b01;
        wdata = {32'h0, 32'h00000022};
        tick();
        check("stall_hold1", rdata[31:0], 32'h00000011);
        wen   = 2'b11;
        waddr = {5'd14, 5'd14};
        wdata = {32'h2, 32'h1};
        tick();
        check("stall_hold2", rdata[31:0], 32'h00000011);
        check("stall_flag", wr_conflict, 1'b1);
        wen   = 2'b00;
        waddr = {5'd0, 5'd9};
        stall = 1'b0;
        tick();
        check("stall_release", rdata[31:0], 32'h00000022);
        check("stall_flag_clear", wr_conflict, 1'b0);

        // Asynchronous reset in the middle of a stall
        stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midstall_rst_rdata", rdata[31:0], 32'h0);
        check("midstall_rst_dbg", dbg_val, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_stall_hold", rdata[31:0], 32'h0);
        stall = 1'b0;
        tick();
        check("post_rst_r9", rdata[31:0], 32'h0);
        wen   = 2'b01;
        wdata = {32'h0, 32'h00000077};
        tick();
        wen = 2'b00;
        tick();
        check("post_rst_write", rdata[31:0], 32'h00000077);

        // Writes to the zero register are discarded and never collide
        wen   = 2'b11;
        waddr = {5'd0, 5'd0};
        wdata = {32'hFFFFFFFF, 32'hFFFFFFFF};
        raddr = {5'd0, 5'd0};
        tick();
        check("zero_noflag", wr_conflict, 1'b0);
        check("zero_edge", rdata[31:0], 32'h0);
        wen = 2'b00;
        tick();
        check("zero_r0_p0", rdata[31:0], 32'h0);
        check("zero_r0_p1", rdata[63:32], 32'h0);

        // 4-read / 1-write 16-bit instance
        b_wen   = 1'b1;
        b_waddr = 5'd3;
        b_wdata = 16'hBEEF;
        b_raddr = {4{5'd3}};
        tick();
        check("b_dbg_commit", b_dbg, 16'hBEEF);
        check("b_rdata_edge", b_rdata, BYP ? {4{16'hBEEF}} : 64'h0);
        b_wen = 1'b0;
        tick();
        check("b_rdata_all4", b_rdata, {4{16'hBEEF}});
        b_wen   = 1'b1;
        b_waddr = 5'd0;
        b_wdata = 16'hFFFF;
        b_raddr = {4{5'd0}};
        tick();
        b_wen = 1'b0;
        tick();
        check("b_r0_writable", b_rdata, {4{16'hFFFF}});
        check("b_noflag", b_conf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
